// File: rtl/reg_access_arbiter.sv
// Two-requester register-file access arbiter.
// Grants one requester at a time (round-robin on ties), drives the
// register-file ports for one cycle, then pulses the matching ack with
// the read or write data.
//
// state | meaning
// IDLE  | waiting for a request; grant decided on the leaving edge
// XFER  | register-file ports driven from the latched transaction
// ACK   | one-cycle ack pulse to the granted requester, rdata valid
module reg_access_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [ADDR_W-1:0] rf_raddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                gnt_q, gnt_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                start;
  logic                gnt_sel;

  // On a tie the requester that did not win last time is served;
  // otherwise whichever single requester is asking.
  assign start   = (state_q == S_IDLE) && (req0 || req1);
  assign gnt_sel = (req0 && req1) ? ~last_grant_q : ~req0;

  // State and transaction registers; reset also aborts any transfer in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  // Next-state, grant latching and read-data capture.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_XFER;
          last_grant_d = gnt_sel;
          gnt_d        = gnt_sel;
          wr_d         = gnt_sel ? wr1    : wr0;
          addr_d       = gnt_sel ? addr1  : addr0;
          wdata_d      = gnt_sel ? wdata1 : wdata0;
        end
      end
      S_XFER: begin
        state_d = S_ACK;
        // A write echoes its own data back so the requester sees what landed.
        rdata_d = wr_q ? wdata_q : rf_rdata;
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Register-file ports are only live during XFER; zero otherwise.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_raddr = '0;
    rf_wdata = '0;
    ack0     = 1'b0;
    ack1     = 1'b0;
    if (state_q == S_XFER) begin
      rf_we    = wr_q;
      rf_waddr = addr_q;
      rf_raddr = addr_q;
      rf_wdata = wdata_q;
    end
    if (state_q == S_ACK) begin
      ack0 = ~gnt_q;
      ack1 = gnt_q;
    end
  end

  assign rdata = rdata_q;
  assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Bench for reg_access_arbiter: directed vector table, hand-written corner
// sequences and randomized traffic against a transaction-level model.
module tb_reg_access_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1, wr0, wr1;
  logic [1:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1, rf_we, busy;
  logic [7:0] rdata, rf_wdata, rf_rdata;
  logic [1:0] rf_waddr, rf_raddr;

  always #5 clk = ~clk;

  reg_access_arbiter #(.DATA_W(8), .ADDR_W(2)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_raddr(rf_raddr),
    .rf_wdata(rf_wdata), .rf_rdata(rf_rdata), .busy(busy)
  );

  // Register file seen by the DUT
  logic [7:0] tb_mem [4] = '{default: 8'h00};
  assign rf_rdata = tb_mem[rf_raddr];
  always @(posedge clk) if (rf_we) tb_mem[rf_waddr] <= rf_wdata;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: a transaction occupies the two cycles after
  // its grant edge (transfer, then acknowledge).
  int         m_left = 0;
  bit         m_last = 1'b1;
  bit         m_who, m_wr;
  logic [1:0] m_addr;
  logic [7:0] m_wdata, m_rdata;
  logic [7:0] m_mem [4] = '{default: 8'h00};
  bit         both_log[$];
  bit         ack_log[$];
  int         ack_cyc[$];

  task automatic model_edge();
    if (m_left == 0) begin
      if (req0 || req1) begin
        m_who   = (req0 && req1) ? ~m_last : ~req0;
        m_last  = m_who;
        m_wr    = m_who ? wr1 : wr0;
        m_addr  = m_who ? addr1 : addr0;
        m_wdata = m_who ? wdata1 : wdata0;
        both_log.push_back(req0 && req1);
        m_left  = 2;
      end
    end else if (m_left == 2) begin
      m_rdata = m_wr ? m_wdata : m_mem[m_addr];
      if (m_wr) m_mem[m_addr] = m_wdata;
      m_left = 1;
    end else begin
      m_left = 0;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic check_model();
    bit xf, ak;
    xf = (m_left == 2);
    ak = (m_left == 1);
    chk("busy", busy, m_left != 0);
    chk("rf_we", rf_we, xf && m_wr);
    chk("rf_waddr", rf_waddr, xf ? m_addr : 2'd0);
    chk("rf_raddr", rf_raddr, xf ? m_addr : 2'd0);
    chk("rf_wdata", rf_wdata, xf ? m_wdata : 8'd0);
    chk("ack0", ack0, ak && !m_who);
    chk("ack1", ack1, ak && m_who);
    if (ak) chk("rdata", rdata, m_rdata);
    if (ack0 || ack1) begin
      ack_log.push_back(ack1);
      ack_cyc.push_back(cyc);
    end
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ack", {ack0, ack1}, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rf_addr", {rf_waddr, rf_raddr, rf_wdata}, 0);
    reset  = 1'b0;
    m_left = 0;
    m_last = 1'b1;
  endtask

  typedef struct {
    bit r0, r1, w0, w1;
    logic [1:0] a0, a1;
    logic [7:0] d0, d1;
    bit e_busy, e_we;
    logic [1:0] e_addr;
    logic [7:0] e_wdata;
    bit e_ack0, e_ack1;
    logic [7:0] e_rdata;
  } vec_t;

  vec_t vt[6];

  initial begin
    int viol;
    // write A5 to reg 2 from requester 0, then read it back from requester 1
    vt[0] = '{1,0,1,0,2'd2,2'd0,8'hA5,8'h00, 1,1,2'd2,8'hA5, 0,0,8'h00};
    vt[1] = '{1,0,1,0,2'd2,2'd0,8'hA5,8'h00, 1,0,2'd0,8'h00, 1,0,8'hA5};
    vt[2] = '{0,1,0,0,2'd0,2'd2,8'h00,8'h3C, 0,0,2'd0,8'h00, 0,0,8'h00};
    vt[3] = '{0,1,0,0,2'd0,2'd2,8'h00,8'h3C, 1,0,2'd2,8'h3C, 0,0,8'h00};
    vt[4] = '{0,1,0,0,2'd0,2'd2,8'h00,8'h3C, 1,0,2'd0,8'h00, 0,1,8'hA5};
    vt[5] = '{0,0,0,0,2'd0,2'd0,8'h00,8'h00, 0,0,2'd0,8'h00, 0,0,8'h00};

    @(negedge clk);
    do_reset();

    for (int i = 0; i < 6; i++) begin
      req0 = vt[i].r0; req1 = vt[i].r1; wr0 = vt[i].w0; wr1 = vt[i].w1;
      addr0 = vt[i].a0; addr1 = vt[i].a1; wdata0 = vt[i].d0; wdata1 = vt[i].d1;
      step();
      chk($sformatf("v%0d_busy", i), busy, vt[i].e_busy);
      chk($sformatf("v%0d_we", i), rf_we, vt[i].e_we);
      chk($sformatf("v%0d_waddr", i), rf_waddr, vt[i].e_addr);
      chk($sformatf("v%0d_raddr", i), rf_raddr, vt[i].e_addr);
      chk($sformatf("v%0d_wdata", i), rf_wdata, vt[i].e_wdata);
      chk($sformatf("v%0d_acks", i), {ack0, ack1}, {vt[i].e_ack0, vt[i].e_ack1});
      if (vt[i].e_ack0 || vt[i].e_ack1) chk($sformatf("v%0d_rdata", i), rdata, vt[i].e_rdata);
    end
    chk("mem2_after_write", tb_mem[2], 8'hA5);

    // Both requesting from reset: order 0,1,0,1 with acks 3 cycles apart
    do_reset();
    ack_log.delete(); ack_cyc.delete();
    req0 = 1; req1 = 1;
    for (int i = 0; i < 12; i++) begin
      step();
      check_model();
    end
    chk("tie_ack_count", ack_log.size(), 4);
    if (ack_log.size() >= 4) begin
      chk("tie_order", {ack_log[0], ack_log[1], ack_log[2], ack_log[3]}, 4'b0101);
      for (int i = 1; i < 4; i++)
        chk("tie_spacing", ack_cyc[i] - ack_cyc[i-1], 3);
    end

    // req1 held, req0 toggled per transaction: no repeat grant on a tie
    do_reset();
    idle_inputs();
    ack_log.delete(); ack_cyc.delete(); both_log.delete();
    req1 = 1; req0 = 1;
    for (int i = 0; i < 30; i++) begin
      step();
      check_model();
      if (ack0 || ack1) req0 = ~req0;
    end
    viol = 0;
    for (int i = 1; i < ack_log.size() && i < both_log.size(); i++)
      if (both_log[i] && ack_log[i] == ack_log[i-1]) viol++;
    chk("rr_alternate", viol, 0);
    chk("rr_ack_count", ack_log.size(), 10);

    // Reset during a write to reg 3 aborts it; next tie goes to requester 0
    idle_inputs();
    while (m_left != 0) begin step(); check_model(); end
    req0 = 1; wr0 = 1; addr0 = 3; wdata0 = 8'h77;
    step();
    check_model();
    chk("abort_we_before", rf_we, 1);
    reset = 1'b1;
    req0 = 0; wr0 = 0;
    #1;
    chk("abort_we", rf_we, 0);
    chk("abort_busy", busy, 0);
    chk("abort_acks", {ack0, ack1}, 0);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    reset = 1'b0;
    m_left = 0; m_last = 1'b1;
    chk("abort_mem3", tb_mem[3], m_mem[3]);
    for (int i = 0; i < 3; i++) begin
      step();
      check_model();
      chk("abort_no_ack", {ack0, ack1}, 0);
    end
    req0 = 1; req1 = 1; wr0 = 0; wr1 = 0;
    step(); check_model();
    req0 = 0; req1 = 0;
    step(); check_model();
    chk("tie_after_reset", {ack0, ack1}, 2'b10);
    step(); check_model();

    // Inputs changing during XFER must not disturb the latched transaction
    req0 = 1; wr0 = 1; addr0 = 1; wdata0 = 8'h5A;
    step(); check_model();
    addr0 = 3; wdata0 = 8'hC3;
    #1;
    chk("latched_waddr", rf_waddr, 2'd1);
    chk("latched_wdata", rf_wdata, 8'h5A);
    step(); check_model();
    chk("latched_rdata", rdata, 8'h5A);
    req0 = 0;
    step(); check_model();

    // Randomized traffic, including requests dropped before grant
    for (int i = 0; i < 400; i++) begin
      req0   = ($urandom_range(0, 3) != 0);
      req1   = ($urandom_range(0, 3) != 0);
      wr0    = $urandom_range(0, 1);
      wr1    = $urandom_range(0, 1);
      addr0  = 2'($urandom_range(0, 3));
      addr1  = 2'($urandom_range(0, 3));
      wdata0 = 8'($urandom);
      wdata1 = 8'($urandom);
      step();
      check_model();
    end
    for (int a = 0; a < 4; a++) chk("final_mem", tb_mem[a], m_mem[a]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_access_arbiter.md
REG_ACCESS_ARBITER -- requirements
Module: reg_access_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_W, default 8, register data width; ADDR_W, default 2, register index width.
REQ-002 clk  input  1  clock; all state updates occur on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0, req1  input  1 each  access request from requester 0 and requester 1; held high until the matching ack.
REQ-005 wr0, wr1  input  1 each  operation select: 1 = write, 0 = read.
REQ-006 addr0, addr1  input  ADDR_W each  target register index.
REQ-007 wdata0, wdata1  input  DATA_W each  write data.
REQ-008 ack0, ack1  output  1 each  one-cycle completion pulse to the served requester.
REQ-009 rdata  output  DATA_W  read result; valid only while ack0 or ack1 is high.
REQ-010 rf_we  output  1  register-file write enable (sigRegWrite).
REQ-011 rf_waddr, rf_raddr  output  ADDR_W each  register-file write index and read-port-1 index.
REQ-012 rf_wdata  output  DATA_W  register-file write data.
REQ-013 rf_rdata  input  DATA_W  register-file readData1, combinational from rf_raddr.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, XFER and ACK.
- IDLE to XFER: on an edge where req0 or req1 is high.
- XFER to ACK: unconditionally after one cycle.
- ACK to IDLE: unconditionally after one cycle.
REQ-016 In IDLE with exactly one request high, that requester SHALL be granted.
REQ-017 In IDLE with both requests high, the requester not recorded in last_grant SHALL be granted (round-robin).
REQ-018 On the IDLE-to-XFER edge, the block SHALL:
- update last_grant to the granted index;
- latch the granted wr, addr and wdata into internal registers.
Requester input changes after that edge SHALL have no effect on the transaction.
REQ-019 In XFER, the outputs SHALL be driven from the latched fields:
- rf_waddr = rf_raddr = latched addr;
- rf_wdata = latched wdata;
- rf_we = latched wr.
REQ-020 Outside XFER, rf_we SHALL be 0, and rf_waddr, rf_raddr and rf_wdata SHALL be 0.
REQ-021 On the XFER-to-ACK edge, rdata SHALL register rf_rdata for a read, and SHALL register the latched wdata for a write.
REQ-022 In ACK, exactly one of ack0/ack1 (the granted requester) SHALL be high for exactly one cycle; both SHALL be 0 in every other state.
REQ-023 Requests SHALL be ignored in XFER and ACK; a requester still high in ACK's following IDLE cycle SHALL be treated as a new request.
REQ-024 Latency SHALL be: request sampled at edge N, rf write at edge N+1, ack high during cycle N+2; sustained throughput is one transaction per 3 cycles.
REQ-025 A request dropped before its ack while the block is not yet in XFER SHALL never be granted; a request dropped during XFER/ACK SHALL still complete.
REQ-026 With both requesters continuously requesting, grants SHALL strictly alternate, so neither requester waits more than one transaction.

Reset
REQ-027 While reset is high, asynchronously, the block SHALL:
- set state = IDLE and last_grant = 1 (requester 0 wins the first tie);
- set ack0 = ack1 = 0, rdata = 0, rf_we = 0, busy = 0;
- clear all latched fields to 0.
REQ-028 A reset asserted in XFER SHALL suppress rf_we immediately, and no ack for the aborted transaction SHALL ever be issued.

Verification
REQ-029 Reset, then req0=1, wr0=1, addr0=2, wdata0=0xA5: rf_we=1, rf_waddr=2, rf_wdata=0xA5 in cycle 1; ack0=1, rdata=0xA5 in cycle 2; ack1 stays 0.
REQ-030 After REQ-029, req1=1, wr1=0, addr1=2 with the register-file model returning 0xA5: rf_raddr=2 in XFER; ack1=1, rdata=0xA5 in ACK.
REQ-031 req0 and req1 both high from reset for 4 transactions: grant order 0,1,0,1; acks spaced 3 cycles apart.
REQ-032 Hold req1 high and toggle req0 high/low each transaction: no two consecutive grants to the same requester while both are high.
REQ-033 Assert reset for 1 cycle during XFER of a write to addr 3: rf_we drops immediately, no ack, busy=0, and the next tie grants requester 0.
REQ-034 Change addr0 and wdata0 during XFER: rf_waddr and rf_wdata keep the values latched at grant.
